cn_msg_expand: RTL and testbench

Serial check-node message regenerator for the QC-LDPC min-sum decoder. It accepts one compressed check-node record per row: min1/min2 magnitudes, min1 edge index, sign parity and per-edge sign vector, which the min-finder tree produces. It then streams the DEG signed check-to-variable messages one per cycle, with valid/ready on both sides. It sits between the check-node record buffer and the variable-node update path.

---
 rtl/cn_pkg.sv | 20 ++
 rtl/cn_msg_sel.sv | 37 +++
 rtl/cn_msg_expand.sv | 151 +++++++++++++++
 tb/tb_cn_msg_expand.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cn_pkg.sv
// Shared types and default widths for the check-node message regenerator.
package cn_pkg;

    localparam int unsigned CN_BITS = 8;
    localparam int unsigned CN_K    = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } cn_state_e;

    // Compressed check-node record kept for the duration of one row
    typedef struct packed {
        logic [CN_BITS-2:0] min1;
        logic [CN_BITS-2:0] min2;
        logic [CN_K-1:0]    idx;
        logic               par;
    } cn_rec_t;

endpackage

// File: rtl/cn_msg_sel.sv
// Per-edge magnitude select, optional offset-min-sum reduction and sign apply.
// Offset reduction is enabled by defining OMS_OFFSET_EN.
module cn_msg_sel
    import cn_pkg::*;
#(
    parameter int unsigned BITS   = CN_BITS,
    parameter int unsigned K      = CN_K,
    parameter int unsigned OFFSET = 1
) (
    input  logic [K-1:0]    edge_i,
    input  logic [K-1:0]    idx_i,
    input  logic [BITS-2:0] min1_i,
    input  logic [BITS-2:0] min2_i,
    input  logic            sgn_i,
    output logic [BITS-1:0] msg_o
);

    // A zero subtrahend makes the reduction below an identity (plain min-sum)
`ifdef OMS_OFFSET_EN
    localparam int unsigned OFFSET_EFF = OFFSET;
`else
    localparam int unsigned OFFSET_EFF = 0 * OFFSET;
`endif
    localparam logic [BITS-2:0] OFF = (BITS-1)'(OFFSET_EFF);

    logic [BITS-2:0] mag;
    logic [BITS-2:0] mag_r;
    logic [BITS-1:0] mag_ext;

    always_comb begin
        mag     = (edge_i == idx_i) ? min2_i : min1_i;
        mag_r   = (mag > OFF) ? (mag - OFF) : '0;
        mag_ext = {1'b0, mag_r};
        msg_o   = sgn_i ? (BITS'(0) - mag_ext) : mag_ext;
    end

endmodule

// File: rtl/cn_msg_expand.sv
// Serial check-node message regenerator: expands one compressed min-sum record
// into DEG signed check-to-variable messages. Optional feature: OMS_OFFSET_EN.
module cn_msg_expand
    import cn_pkg::*;
#(
    parameter int unsigned BITS   = CN_BITS,
    parameter int unsigned DEG    = 32,
    parameter int unsigned K      = CN_K,
    parameter int unsigned OFFSET = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-2:0] in_min1,
    input  logic [BITS-2:0] in_min2,
    input  logic [K-1:0]    in_idx,
    input  logic            in_par,
    input  logic [DEG-1:0]  in_sgn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_msg,
    output logic [K-1:0]    out_edge,
    output logic            out_last
);

    localparam logic [K-1:0] LAST_EDGE = K'(DEG - 1);

    cn_state_e       state_q, state_d;
    cn_rec_t         rec_q, rec_d;
    logic [DEG-1:0]  sgn_q, sgn_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_msg_q, out_msg_d;
    logic [K-1:0]    out_edge_q, out_edge_d;
    logic            out_last_q, out_last_d;

    logic            accept;
    logic            advance;
    logic [K-1:0]    sel_edge;
    logic [K-1:0]    sel_idx;
    logic [BITS-2:0] sel_min1;
    logic [BITS-2:0] sel_min2;
    logic            sel_sgn;
    logic [BITS-1:0] sel_msg;

    assign in_ready = (state_q == IDLE) | (out_valid_q & out_ready & out_last_q);
    assign accept   = in_valid & in_ready;
    assign advance  = out_valid_q & out_ready;

    // The selector sees the incoming record (edge 0) on a load, else the held record at e+1
    always_comb begin
        sel_edge = out_edge_q + K'(1);
        sel_idx  = K'(rec_q.idx);
        sel_min1 = (BITS-1)'(rec_q.min1);
        sel_min2 = (BITS-1)'(rec_q.min2);
        sel_sgn  = rec_q.par ^ sgn_q[sel_edge];
        if (accept) begin
            sel_edge = '0;
            sel_idx  = in_idx;
            sel_min1 = in_min1;
            sel_min2 = in_min2;
            sel_sgn  = in_par ^ in_sgn[0];
        end
    end

    cn_msg_sel #(
        .BITS   (BITS),
        .K      (K),
        .OFFSET (OFFSET)
    ) u_sel (
        .edge_i (sel_edge),
        .idx_i  (sel_idx),
        .min1_i (sel_min1),
        .min2_i (sel_min2),
        .sgn_i  (sel_sgn),
        .msg_o  (sel_msg)
    );

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        sgn_d       = sgn_q;
        out_valid_d = out_valid_q;
        out_msg_d   = out_msg_q;
        out_edge_d  = out_edge_q;
        out_last_d  = out_last_q;

        if (accept) begin
            state_d     = STREAM;
            rec_d.min1  = (CN_BITS-1)'(in_min1);
            rec_d.min2  = (CN_BITS-1)'(in_min2);
            rec_d.idx   = CN_K'(in_idx);
            rec_d.par   = in_par;
            sgn_d       = in_sgn;
            out_valid_d = 1'b1;
            out_msg_d   = sel_msg;
            out_edge_d  = '0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_d = 1'b0;
                end
                STREAM: begin
                    if (advance) begin
                        if (out_last_q) begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end else begin
                            out_msg_d  = sel_msg;
                            out_edge_d = sel_edge;
                            out_last_d = (sel_edge == LAST_EDGE);
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rec_q       <= '0;
            sgn_q       <= '0;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_edge_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            sgn_q       <= sgn_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            out_edge_q  <= out_edge_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_msg   = out_msg_q;
    assign out_edge  = out_edge_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_cn_msg_expand.sv
// Scoreboard bench for cn_msg_expand: expected beats are queued on record accept
// and checked on every falling edge while the DUT streams.
module tb_cn_msg_expand;

    localparam int unsigned BITS   = 8;
    localparam int unsigned DEG    = 32;
    localparam int unsigned K      = 5;
    localparam int unsigned OFFSET = 1;

    typedef struct packed {
        logic [BITS-1:0] msg;
        logic [K-1:0]    edg;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-2:0] in_min1;
    logic [BITS-2:0] in_min2;
    logic [K-1:0]    in_idx;
    logic            in_par;
    logic [DEG-1:0]  in_sgn;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_msg;
    logic [K-1:0]    out_edge;
    logic            out_last;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    cn_msg_expand #(
        .BITS   (BITS),
        .DEG    (DEG),
        .K      (K),
        .OFFSET (OFFSET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_min1   (in_min1),
        .in_min2   (in_min2),
        .in_idx    (in_idx),
        .in_par    (in_par),
        .in_sgn    (in_sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_edge  (out_edge),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [BITS-1:0] model_msg(input int m1, input int m2, input int ix,
                                                  input bit p, input bit sg, input int e);
        int mag;
        int v;
        mag = (e == ix) ? m2 : m1;
`ifdef OMS_OFFSET_EN
        mag = (mag > int'(OFFSET)) ? mag - int'(OFFSET) : 0;
`endif
        v = (p ^ sg) ? -mag : mag;
        return BITS'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compares the head of the scoreboard; a held beat is compared again next cycle
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("out_msg",  32'(out_msg),  32'(sb[0].msg));
                check("out_edge", 32'(out_edge), 32'(sb[0].edg));
                check("out_last", 32'(out_last), 32'(sb[0].last));
                check("in_ready_stream", 32'(in_ready), 32'(out_ready & sb[0].last));
                if (out_ready) void'(sb.pop_front());
            end else begin
                check("in_ready_idle", 32'(in_ready), 32'd1);
            end
        end
    end

    task automatic send(input int m1, input int m2, input int ix, input bit p,
                        input logic [DEG-1:0] s);
        int   cyc = 0;
        bit   acc = 1'b0;
        exp_t ex;
        in_min1  = (BITS-1)'(m1);
        in_min2  = (BITS-1)'(m2);
        in_idx   = K'(ix);
        in_par   = p;
        in_sgn   = s;
        in_valid = 1'b1;
        while (!acc && cyc < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("send_accept", 32'(acc), 32'd1);
        if (acc) begin
            for (int e = 0; e < int'(DEG); e++) begin
                ex.msg  = model_msg(m1, m2, ix, p, s[e], e);
                ex.edg  = K'(e);
                ex.last = (e == int'(DEG) - 1);
                sb.push_back(ex);
            end
        end
    endtask

    task automatic drain(input bit toggle);
        int         cyc = 0;
        logic [3:0] pat = 4'b1001;
        while (sb.size() != 0 && cyc < 500) begin
            if (toggle) out_ready = pat[2'(cyc)];
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b1;
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_min1   = '0;
        in_min2   = '0;
        in_idx    = '0;
        in_par    = 1'b0;
        in_sgn    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_msg",   32'(out_msg),   32'd0);
        check("rst_out_edge",  32'(out_edge),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic row: min2 only on the min1 edge
        send(3, 5, 2, 1'b0, '0);
        drain(1'b0);

        // Parity with one set sign bit: that edge becomes positive
        send(7, 9, 4, 1'b1, DEG'(1) << 4);
        drain(1'b0);

        // Back-to-back rows with in_valid held, including zero and full-scale magnitudes
        send(0, 127, 31, 1'b0, DEG'($urandom));
        send(127, 126, 0, 1'b1, DEG'($urandom));
        send(12, 40, 17, 1'b0, DEG'($urandom));
        drain(1'b0);

        // Downstream stalls with out_ready pattern 1,0,0,1
        send(20, 33, 9, 1'b1, DEG'($urandom));
        drain(1'b1);

        // Reset mid-row at edge 10
        send(5, 6, 3, 1'b0, DEG'($urandom));
        cyc = 0;
        while (out_edge !== K'(10) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reached_edge10", 32'(out_edge), 32'd10);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_edge",  32'(out_edge),  32'd0);
        check("midrst_out_msg",   32'(out_msg),   32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(11, 14, 30, 1'b1, DEG'($urandom));
        drain(1'b1);

        // Small magnitudes: exercises the offset reduction when it is built in
        send(1, 2, 0, 1'b1, '0);
        drain(1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
